// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_seq_ctrl
// Description : Sequencer for one matrix-multiply job on an N x N systolic
//               array. Accepts a command, fetches K operand slices, feeds
//               them to the array (last slice tagged), waits for the skewed
//               wavefront to flush, then drains N result rows to memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst              clock / synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_i                 {compute_req, drain_en, a_addr, b_addr, c_addr}
//   cmd_k_i               inner dimension K (number of feed steps)
//   rd_req_o/rd_ack_i     operand slice read handshake
//   rd_a/b_addr_o         A/B slice addresses
//   feed_valid_o/last_o   slice enters the array / final slice
//   drain_en_o            array shifts results out
//   wr_valid_o/ready_i    C row write handshake
//   wr_addr_o             C row address
//   busy_o, done_o        job in progress / one-cycle completion pulse
// ============================================================================
module systolic_seq_ctrl #(
    parameter int SYS_ARRAY_SIZE = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 64,
    parameter int K_WIDTH        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2+3*ADDR_WIDTH-1:0] cmd_i,
    input  logic [K_WIDTH-1:0]        cmd_k_i,
    output logic                      rd_req_o,
    input  logic                      rd_ack_i,
    output logic [ADDR_WIDTH-1:0]     rd_a_addr_o,
    output logic [ADDR_WIDTH-1:0]     rd_b_addr_o,
    output logic                      feed_valid_o,
    output logic                      feed_last_o,
    output logic                      drain_en_o,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    output logic [ADDR_WIDTH-1:0]     wr_addr_o,
    output logic                      busy_o,
    output logic                      done_o
);

    // Element size in address units; one byte-wide element per address.
    localparam int c_ELEM_BYTES = (DATA_WIDTH + 7) / 8;
    localparam logic [ADDR_WIDTH-1:0] c_STRIDE =
        ADDR_WIDTH'(SYS_ARRAY_SIZE * c_ELEM_BYTES);
    localparam int c_FLUSH_W = $clog2(2 * SYS_ARRAY_SIZE + 1);
    localparam int c_ROW_W   = $clog2(SYS_ARRAY_SIZE + 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(2 * SYS_ARRAY_SIZE - 1);
    localparam logic [c_ROW_W-1:0]   c_ROW_LAST   = c_ROW_W'(SYS_ARRAY_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    // Running addresses: base + step*N kept as accumulators (wrap naturally).
    logic [ADDR_WIDTH-1:0]  a_addr_q, a_addr_d;
    logic [ADDR_WIDTH-1:0]  b_addr_q, b_addr_d;
    logic [ADDR_WIDTH-1:0]  c_addr_q, c_addr_d;
    logic                   drain_q, drain_d;
    logic [K_WIDTH-1:0]     k_q, k_d;
    logic [K_WIDTH-1:0]     step_q, step_d;
    logic [c_FLUSH_W-1:0]   flush_q, flush_d;
    logic [c_ROW_W-1:0]     row_q, row_d;
    logic                   feed_valid_q, feed_valid_d;
    logic                   feed_last_q, feed_last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            c_addr_q     <= '0;
            drain_q      <= 1'b0;
            k_q          <= '0;
            step_q       <= '0;
            flush_q      <= '0;
            row_q        <= '0;
            feed_valid_q <= 1'b0;
            feed_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_addr_q     <= a_addr_d;
            b_addr_q     <= b_addr_d;
            c_addr_q     <= c_addr_d;
            drain_q      <= drain_d;
            k_q          <= k_d;
            step_q       <= step_d;
            flush_q      <= flush_d;
            row_q        <= row_d;
            feed_valid_q <= feed_valid_d;
            feed_last_q  <= feed_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_addr_d     = a_addr_q;
        b_addr_d     = b_addr_q;
        c_addr_d     = c_addr_q;
        drain_d      = drain_q;
        k_d          = k_q;
        step_d       = step_q;
        flush_d      = flush_q;
        row_d        = row_q;
        feed_valid_d = 1'b0;
        feed_last_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    drain_d  = cmd_i[2+3*ADDR_WIDTH-2];
                    a_addr_d = cmd_i[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
                    b_addr_d = cmd_i[2*ADDR_WIDTH-1:ADDR_WIDTH];
                    c_addr_d = cmd_i[ADDR_WIDTH-1:0];
                    k_d      = cmd_k_i;
                    step_d   = '0;
                    flush_d  = '0;
                    row_d    = '0;
                    // A non-compute command is simply consumed.
                    if (cmd_i[2+3*ADDR_WIDTH-1]) begin
                        state_d = (cmd_k_i == '0) ? S_DONE : S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (rd_ack_i) begin
                    feed_valid_d = 1'b1;
                    step_d       = step_q + K_WIDTH'(1);
                    a_addr_d     = a_addr_q + c_STRIDE;
                    b_addr_d     = b_addr_q + c_STRIDE;
                    if (step_q == k_q - K_WIDTH'(1)) begin
                        feed_last_d = 1'b1;
                        state_d     = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // First FLUSH cycle coincides with the final feed pulse.
                flush_d = flush_q + c_FLUSH_W'(1);
                if (flush_q == c_FLUSH_LAST) begin
                    state_d = drain_q ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (wr_ready_i) begin
                    row_d    = row_q + c_ROW_W'(1);
                    c_addr_d = c_addr_q + c_STRIDE;
                    if (row_q == c_ROW_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is asserted, independent of the
    // state register still holding the abandoned job for this cycle.
    logic out_en;

    always_comb begin
        out_en       = ~rst;
        cmd_ready_o  = out_en && (state_q == S_IDLE);
        rd_req_o     = out_en && (state_q == S_FETCH);
        rd_a_addr_o  = rd_req_o ? a_addr_q : '0;
        rd_b_addr_o  = rd_req_o ? b_addr_q : '0;
        feed_valid_o = out_en && feed_valid_q;
        feed_last_o  = out_en && feed_last_q;
        drain_en_o   = out_en && (state_q == S_DRAIN);
        wr_valid_o   = out_en && (state_q == S_DRAIN);
        wr_addr_o    = wr_valid_o ? c_addr_q : '0;
        busy_o       = out_en && (state_q != S_IDLE);
        done_o       = out_en && (state_q == S_DONE);
    end

endmodule
`default_nettype wire
